// File: rtl/sobel_magnitude_sqrt_if.sv
// Handshake and operand bus between the Nios custom-instruction port and
// the Sobel gradient-magnitude square-root unit.
`timescale 1ns/1ps

interface sobel_magnitude_sqrt_if;
   logic        clk_en;
   logic        start;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic        done;
   logic [31:0] result;

   modport master (
      output clk_en, start, dataa, datab,
      input  done, result
   );

   modport slave (
      input  clk_en, start, dataa, datab,
      output done, result
   );
endinterface

// File: rtl/sobel_magnitude_sqrt.sv
// floor(sqrt(Gx^2 + Gy^2)) by restoring digit-by-digit square root, one root bit per cycle.
// Optional macro SOBEL_MAG_CLAMP_EN saturates the result to an 8-bit pixel (255).
`timescale 1ns/1ps

module sobel_magnitude_sqrt #(
   parameter int ITER = 17
) (
   input  logic                 clk,
   input  logic                 reset,
   sobel_magnitude_sqrt_if.slave bus
);

   localparam int RW = 2 * ITER;
   localparam int MW = ITER + 2;
   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t          state, next_state;
   logic [RW-1:0]   rad, rad_n;
   logic [MW-1:0]   rem, rem_n;
   logic [ITER-1:0] root, root_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            done, done_n;
   logic [31:0]     result, result_n;

   logic [32:0]     sum;
   logic [MW-1:0]   rem_shift;
   logic [MW-1:0]   trial;
   logic [31:0]     root_ext;

   assign sum       = {1'b0, bus.dataa} + {1'b0, bus.datab};
   assign rem_shift = {rem[ITER-1:0], rad[RW-1 -: 2]};
   assign trial     = {root, 2'b01};
   assign root_ext  = 32'(root);

   // A start is only taken from a quiet IDLE, so one arriving alongside done is dropped.
   always_comb begin
      next_state = state;
      rad_n      = rad;
      rem_n      = rem;
      root_n     = root;
      cnt_n      = cnt;
      done_n     = 1'b0;
      result_n   = result;
      case (state)
         IDLE: begin
            if (bus.start && !done) begin
               rad_n      = RW'(sum);
               rem_n      = '0;
               root_n     = '0;
               cnt_n      = CW'(ITER - 1);
               next_state = CALC;
            end
         end
         CALC: begin
            rad_n = rad << 2;
            if (rem_shift >= trial) begin
               rem_n  = rem_shift - trial;
               root_n = {root[ITER-2:0], 1'b1};
            end else begin
               rem_n  = rem_shift;
               root_n = {root[ITER-2:0], 1'b0};
            end
            if (cnt == '0) begin
               next_state = FIN;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         FIN: begin
            done_n = 1'b1;
`ifdef SOBEL_MAG_CLAMP_EN
            result_n = (root_ext > 32'd255) ? 32'd255 : root_ext;
`else
            result_n = root_ext;
`endif
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Every register, including a raised done, freezes while clk_en is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         rad    <= '0;
         rem    <= '0;
         root   <= '0;
         cnt    <= '0;
         done   <= 1'b0;
         result <= '0;
      end else if (bus.clk_en) begin
         state  <= next_state;
         rad    <= rad_n;
         rem    <= rem_n;
         root   <= root_n;
         cnt    <= cnt_n;
         done   <= done_n;
         result <= result_n;
      end
   end

   assign bus.done   = done;
   assign bus.result = result;

endmodule

// File: tb/tb_sobel_magnitude_sqrt.sv
// Self-checking bench for sobel_magnitude_sqrt: directed corner cases plus random
// operands against an integer-square-root model (honours SOBEL_MAG_CLAMP_EN).
`timescale 1ns/1ps

module tb_sobel_magnitude_sqrt;

   logic clk = 1'b0;
   logic reset;

   sobel_magnitude_sqrt_if bus ();

   sobel_magnitude_sqrt #(.ITER(17)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int total_cnt = 0;
   int pass_cnt  = 0;

`ifdef SOBEL_MAG_CLAMP_EN
   localparam logic [31:0] MAX_MAG = 32'd255;
`else
   localparam logic [31:0] MAX_MAG = 32'h16A09;
`endif

   // Largest r with r*r <= a+b, found by binary search on the full-precision sum.
   function automatic logic [31:0] ref_mag(input logic [31:0] a, input logic [31:0] b);
      longint unsigned s, lo, hi, mid;
      s  = {32'b0, a} + {32'b0, b};
      lo = 0;
      hi = 64'd1 << 17;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= s) lo = mid;
         else hi = mid - 1;
      end
`ifdef SOBEL_MAG_CLAMP_EN
      if (lo > 255) lo = 255;
`endif
      return 32'(lo);
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Issues one operation and counts clocks from the start edge until done is seen.
   task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                 input int stall_at, input int stall_len,
                                 input int inject_at, output int cycles);
      @(negedge clk);
      bus.dataa  = a;
      bus.datab  = b;
      bus.start  = 1'b1;
      bus.clk_en = 1'b1;
      cycles = -1;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done === 1'b1) begin
            cycles = k;
            break;
         end
         bus.start = (k == inject_at);
         if (k == inject_at) begin
            bus.dataa = 32'd1;
            bus.datab = 32'd0;
         end
         bus.clk_en = !(k >= stall_at && k < stall_at + stall_len);
      end
      bus.start  = 1'b0;
      bus.clk_en = 1'b1;
   endtask

   task automatic check_pulse_end(input string tag, input logic [31:0] exp_result);
      @(posedge clk);
      @(negedge clk);
      check_output({tag, "_done_low"}, 64'(bus.done), 64'd0);
      check_output({tag, "_result_hold"}, 64'(bus.result), 64'(exp_result));
   endtask

   task automatic count_spurious_done(input int n, output int highs);
      highs = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done !== 1'b0) highs++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_result);
      int cycles;
      apply_stimulus(a, b, -1, 0, -1, cycles);
      check_output({tag, "_latency"}, 64'(cycles), 64'd18);
      check_output({tag, "_result"}, 64'(bus.result), 64'(exp_result));
      check_pulse_end(tag, exp_result);
   endtask

   initial begin
      int cycles;
      int highs;
      logic [31:0] ra, rb;

      reset      = 1'b0;
      bus.clk_en = 1'b1;
      bus.start  = 1'b0;
      bus.dataa  = '0;
      bus.datab  = '0;
      repeat (3) @(negedge clk);
      check_output("reset_done", 64'(bus.done), 64'd0);
      check_output("reset_result", 64'(bus.result), 64'd0);
      reset = 1'b1;

      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         check_output("idle_done", 64'(bus.done), 64'd0);
         check_output("idle_result", 64'(bus.result), 64'd0);
      end

      run_op("sum25", 32'd9, 32'd16, 32'd5);
      run_op("floor24", 32'd24, 32'd0, 32'd4);
      run_op("zero", 32'd0, 32'd0, 32'd0);
      run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, MAX_MAG);

      // done must stay high while the enable is withheld
      apply_stimulus(32'd65025, 32'd1, -1, 0, -1, cycles);
      check_output("p255_latency", 64'(cycles), 64'd18);
      check_output("p255_result", 64'(bus.result), 64'd255);
      bus.clk_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         check_output("done_held", 64'(bus.done), 64'd1);
      end
      bus.clk_en = 1'b1;
      check_pulse_end("p255", 32'd255);

      // start coinciding with done is dropped
      apply_stimulus(32'd9, 32'd0, -1, 0, -1, cycles);
      check_output("busy_latency", 64'(cycles), 64'd18);
      bus.dataa = 32'd400;
      bus.datab = 32'd0;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      count_spurious_done(25, highs);
      check_output("start_on_done_ignored", 64'(highs), 64'd0);
      check_output("start_on_done_result", 64'(bus.result), 64'd3);

      apply_stimulus(32'd100, 32'd0, 6, 4, 3, cycles);
      check_output("stall_latency", 64'(cycles), 64'd22);
      check_output("stall_result", 64'(bus.result), 64'd10);
      check_pulse_end("stall", 32'd10);

      for (int n = 0; n < 8; n++) begin
         if (n < 4) begin
            ra = $urandom;
            rb = $urandom;
         end else begin
            ra = $urandom_range(0, 70000);
            rb = $urandom_range(0, 70000);
         end
         run_op($sformatf("rand%0d", n), ra, rb, ref_mag(ra, rb));
      end

      // reset in mid-calculation aborts without a done pulse
      @(negedge clk);
      bus.dataa = 32'd49;
      bus.datab = 32'd0;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("abort_done", 64'(bus.done), 64'd0);
      check_output("abort_result", 64'(bus.result), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      count_spurious_done(25, highs);
      check_output("abort_no_done", 64'(highs), 64'd0);
      run_op("after_abort", 32'd64, 32'd0, 32'd8);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
